refresh_arbiter: RTL and testbench



---
 rtl/refresh_arbiter.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_refresh_arbiter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/refresh_arbiter.sv
// refresh_arbiter
//   Merges the host command stream with periodic DDR4 auto-refresh on the
//   4-slot command bus (c0_ddr4_clk domain). A refresh runs as
//   DRAIN -> PREA -> wait tRP -> REF -> wait tRFC and only starts at a
//   command boundary. Host traffic may postpone refresh until POSTPONE_MAX
//   refreshes are owed, after which refresh preempts the host.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ref_en            enables the interval timer and refresh launch
//   cmd_valid/ready   host command handshake
//   cmd_type/ap/bg/bank/row/col  host command fields
//   ddr_*             registered per-slot command flags and addresses;
//                     only slot 0 carries commands, slots 1-3 are NOP
//   ref_pending       refreshes owed
//   ref_issued        REF commands issued by this block (wraps)
//   ref_overflow      sticky: interval expired with the owed count saturated
module refresh_arbiter #(
    parameter int unsigned BG_WIDTH     = 2,
    parameter int unsigned BANK_WIDTH   = 2,
    parameter int unsigned COL_WIDTH    = 10,
    parameter int unsigned ROW_WIDTH    = 17,
    parameter int unsigned T_REFI       = 7800,
    parameter int unsigned T_RP         = 16,
    parameter int unsigned T_RFC        = 350,
    parameter int unsigned T_DRAIN      = 8,
    parameter int unsigned POSTPONE_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ref_en,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_type,
    input  logic                    cmd_ap,
    input  logic [BG_WIDTH-1:0]     cmd_bg,
    input  logic [BANK_WIDTH-1:0]   cmd_bank,
    input  logic [ROW_WIDTH-1:0]    cmd_row,
    input  logic [COL_WIDTH-1:0]    cmd_col,
    output logic [3:0]              ddr_write,
    output logic [3:0]              ddr_read,
    output logic [3:0]              ddr_pre,
    output logic [3:0]              ddr_act,
    output logic [3:0]              ddr_ref,
    output logic [3:0]              ddr_zq,
    output logic [3:0]              ddr_nop,
    output logic [3:0]              ddr_ap,
    output logic [3:0]              ddr_pall,
    output logic [4*BG_WIDTH-1:0]   ddr_bg,
    output logic [4*BANK_WIDTH-1:0] ddr_bank,
    output logic [4*COL_WIDTH-1:0]  ddr_col,
    output logic [4*ROW_WIDTH-1:0]  ddr_row,
    output logic [3:0]              ref_pending,
    output logic [31:0]             ref_issued,
    output logic                    ref_overflow
);

    localparam int unsigned TimerW = (T_REFI > 1) ? $clog2(T_REFI) : 1;
    localparam int unsigned CntMax =
        (T_RFC > T_DRAIN) ? ((T_RFC > T_RP) ? T_RFC : T_RP)
                          : ((T_DRAIN > T_RP) ? T_DRAIN : T_RP);
    localparam int unsigned CntW = $clog2(CntMax + 1);

    localparam logic [TimerW-1:0] TimerLast = TimerW'(T_REFI - 1);
    localparam logic [CntW-1:0]   DrainLoad = CntW'(T_DRAIN);
    // PREA itself is the first of the T_RP cycles, so the wait is one shorter.
    localparam logic [CntW-1:0]   RpLoad    = CntW'(T_RP - 1);
    localparam logic [CntW-1:0]   RfcLoad   = CntW'(T_RFC);
    localparam logic [CntW-1:0]   CntOne    = CntW'(1);
    localparam logic [3:0]        PendMax   = 4'(POSTPONE_MAX);

    localparam logic [2:0] CmdNop  = 3'd0;
    localparam logic [2:0] CmdAct  = 3'd1;
    localparam logic [2:0] CmdRd   = 3'd2;
    localparam logic [2:0] CmdWr   = 3'd3;
    localparam logic [2:0] CmdPre  = 3'd4;
    localparam logic [2:0] CmdPrea = 3'd5;
    localparam logic [2:0] CmdRef  = 3'd6;
    localparam logic [2:0] CmdZq   = 3'd7;

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StPrea,
        StWaitRp,
        StRef,
        StWaitRfc
    } state_e;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [3:0]          pending_q, pending_d;
    logic [31:0]         issued_q, issued_d;
    logic                overflow_q, overflow_d;

    // Slot 0 registered command
    logic                   wr_q, rd_q, pre_q, act_q, ref_q, zq_q, nop_q, ap_q, pall_q;
    logic [BG_WIDTH-1:0]    bg_q;
    logic [BANK_WIDTH-1:0]  bank_q;
    logic [COL_WIDTH-1:0]   col_q;
    logic [ROW_WIDTH-1:0]   row_q;

    logic expire, go_ref, accept, ref_fire;

    assign expire   = ref_en && (timer_q == TimerLast);
    assign go_ref   = ref_en && (pending_q != 4'd0) && (!cmd_valid || (pending_q >= PendMax));
    assign cmd_ready = !rst && (state_q == StIdle) && !go_ref;
    assign accept   = cmd_valid && cmd_ready;
    assign ref_fire = (state_q == StRef);

    // Interval timer and refresh bookkeeping
    always_comb begin
        timer_d    = timer_q;
        pending_d  = pending_q;
        issued_d   = issued_q;
        overflow_d = overflow_q;

        if (!ref_en || expire) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        if (expire && (pending_q >= PendMax)) begin
            overflow_d = 1'b1;
        end

        // Expire and REF in the same cycle cancel out.
        if (expire && !ref_fire) begin
            if (pending_q < PendMax) begin
                pending_d = pending_q + 4'd1;
            end
        end else if (ref_fire && !expire && (pending_q != 4'd0)) begin
            pending_d = pending_q - 4'd1;
        end

        if (ref_fire) begin
            issued_d = issued_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q    <= '0;
            pending_q  <= '0;
            issued_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            issued_q   <= issued_d;
            overflow_q <= overflow_d;
        end
    end

    // Sequencer with registered slot-0 outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            pre_q   <= 1'b0;
            act_q   <= 1'b0;
            ref_q   <= 1'b0;
            zq_q    <= 1'b0;
            nop_q   <= 1'b1;
            ap_q    <= 1'b0;
            pall_q  <= 1'b0;
            bg_q    <= '0;
            bank_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            // Slot 0 idles as NOP unless something below issues.
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            pre_q  <= 1'b0;
            act_q  <= 1'b0;
            ref_q  <= 1'b0;
            zq_q   <= 1'b0;
            nop_q  <= 1'b1;
            ap_q   <= 1'b0;
            pall_q <= 1'b0;
            bg_q   <= '0;
            bank_q <= '0;
            col_q  <= '0;
            row_q  <= '0;

            unique case (state_q)
                StIdle: begin
                    if (go_ref) begin
                        cnt_q   <= DrainLoad;
                        state_q <= StDrain;
                    end else if (accept) begin
                        if (cmd_type != CmdNop) begin
                            nop_q  <= 1'b0;
                            bg_q   <= cmd_bg;
                            bank_q <= cmd_bank;
                        end
                        unique case (cmd_type)
                            CmdNop:  ;
                            CmdAct: begin
                                act_q <= 1'b1;
                                row_q <= cmd_row;
                            end
                            CmdRd: begin
                                rd_q  <= 1'b1;
                                ap_q  <= cmd_ap;
                                col_q <= cmd_col;
                            end
                            CmdWr: begin
                                wr_q  <= 1'b1;
                                ap_q  <= cmd_ap;
                                col_q <= cmd_col;
                            end
                            CmdPre:  pre_q <= 1'b1;
                            CmdPrea: begin
                                pre_q  <= 1'b1;
                                pall_q <= 1'b1;
                            end
                            CmdRef:  ref_q <= 1'b1;
                            CmdZq:   zq_q  <= 1'b1;
                        endcase
                    end
                end
                StDrain: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntOne) begin
                        state_q <= StPrea;
                    end
                end
                StPrea: begin
                    pre_q  <= 1'b1;
                    pall_q <= 1'b1;
                    nop_q  <= 1'b0;
                    if (T_RP == 1) begin
                        state_q <= StRef;
                    end else begin
                        cnt_q   <= RpLoad;
                        state_q <= StWaitRp;
                    end
                end
                StWaitRp: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntOne) begin
                        state_q <= StRef;
                    end
                end
                StRef: begin
                    ref_q   <= 1'b1;
                    nop_q   <= 1'b0;
                    cnt_q   <= RfcLoad;
                    state_q <= StWaitRfc;
                end
                StWaitRfc: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CntOne) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ddr_write = {3'b000, wr_q};
    assign ddr_read  = {3'b000, rd_q};
    assign ddr_pre   = {3'b000, pre_q};
    assign ddr_act   = {3'b000, act_q};
    assign ddr_ref   = {3'b000, ref_q};
    assign ddr_zq    = {3'b000, zq_q};
    assign ddr_nop   = {3'b111, nop_q};
    assign ddr_ap    = {3'b000, ap_q};
    assign ddr_pall  = {3'b000, pall_q};
    assign ddr_bg    = {{(3*BG_WIDTH){1'b0}}, bg_q};
    assign ddr_bank  = {{(3*BANK_WIDTH){1'b0}}, bank_q};
    assign ddr_col   = {{(3*COL_WIDTH){1'b0}}, col_q};
    assign ddr_row   = {{(3*ROW_WIDTH){1'b0}}, row_q};

    assign ref_pending  = pending_q;
    assign ref_issued   = issued_q;
    assign ref_overflow = overflow_q;

endmodule

// File: tb/tb_refresh_arbiter.sv
// Directed bench for refresh_arbiter. dut uses T_REFI=100; dut2 uses a short
// T_REFI=10 so expiries outrun refreshes and the owed count saturates.
module tb_refresh_arbiter;

    logic clk = 1'b0;
    logic rst, ref_en, cmd_valid, cmd_ap;
    logic [2:0]  cmd_type;
    logic [1:0]  cmd_bg, cmd_bank;
    logic [16:0] cmd_row;
    logic [9:0]  cmd_col;

    logic        cmd_ready;
    logic [3:0]  ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq, ddr_nop, ddr_ap, ddr_pall;
    logic [7:0]  ddr_bg, ddr_bank;
    logic [39:0] ddr_col;
    logic [67:0] ddr_row;
    logic [3:0]  ref_pending;
    logic [31:0] ref_issued;
    logic        ref_overflow;

    logic        b_cmd_ready;
    logic [3:0]  b_write, b_read, b_pre, b_act, b_ref, b_zq, b_nop, b_ap, b_pall;
    logic [7:0]  b_bg, b_bank;
    logic [39:0] b_col;
    logic [67:0] b_row;
    logic [3:0]  b_pending;
    logic [31:0] b_issued;
    logic        b_overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    refresh_arbiter #(
        .T_REFI(100), .T_RP(4), .T_RFC(20), .T_DRAIN(3), .POSTPONE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst), .ref_en(ref_en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_type(cmd_type), .cmd_ap(cmd_ap), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col),
        .ddr_write(ddr_write), .ddr_read(ddr_read), .ddr_pre(ddr_pre), .ddr_act(ddr_act),
        .ddr_ref(ddr_ref), .ddr_zq(ddr_zq), .ddr_nop(ddr_nop), .ddr_ap(ddr_ap),
        .ddr_pall(ddr_pall), .ddr_bg(ddr_bg), .ddr_bank(ddr_bank), .ddr_col(ddr_col),
        .ddr_row(ddr_row), .ref_pending(ref_pending), .ref_issued(ref_issued),
        .ref_overflow(ref_overflow)
    );

    refresh_arbiter #(
        .T_REFI(10), .T_RP(4), .T_RFC(20), .T_DRAIN(3), .POSTPONE_MAX(4)
    ) dut2 (
        .clk(clk), .rst(rst), .ref_en(ref_en), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_type(cmd_type), .cmd_ap(cmd_ap), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank),
        .cmd_row(cmd_row), .cmd_col(cmd_col),
        .ddr_write(b_write), .ddr_read(b_read), .ddr_pre(b_pre), .ddr_act(b_act),
        .ddr_ref(b_ref), .ddr_zq(b_zq), .ddr_nop(b_nop), .ddr_ap(b_ap),
        .ddr_pall(b_pall), .ddr_bg(b_bg), .ddr_bank(b_bank), .ddr_col(b_col),
        .ddr_row(b_row), .ref_pending(b_pending), .ref_issued(b_issued),
        .ref_overflow(b_overflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    // Leaves rst deasserted with cyc = 0 at the first post-reset cycle.
    task automatic do_reset();
        rst = 1'b1; ref_en = 1'b0; cmd_valid = 1'b0; cmd_type = 3'd0; cmd_ap = 1'b0;
        cmd_bg = '0; cmd_bank = '0; cmd_row = '0; cmd_col = '0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ref_en = 1'b0; cmd_valid = 1'b0; cmd_type = 3'd1; cmd_ap = 1'b0;
        cmd_bg = '0; cmd_bank = '0; cmd_row = '0; cmd_col = '0;
        tick();
        tick();
        checks++;
        if ({ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq, ddr_ap, ddr_pall} !== 32'h0
            || ddr_nop !== 4'hf) begin
            failures++;
            $display("FAIL reset_flags: got nop=%h others=%h expected nop=f others=0", ddr_nop,
                     {ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq, ddr_ap, ddr_pall});
        end
        checks++;
        if ({ddr_bg, ddr_bank, ddr_col, ddr_row} !== 124'h0) begin
            failures++;
            $display("FAIL reset_addr: got %h expected 0", {ddr_bg, ddr_bank, ddr_col, ddr_row});
        end
        checks++;
        if ({cmd_ready, ref_pending, ref_issued, ref_overflow} !== 38'h0) begin
            failures++;
            $display("FAIL reset_status: got ready=%b pend=%0d iss=%0d ovf=%b expected all 0",
                     cmd_ready, ref_pending, ref_issued, ref_overflow);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle_ready: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_refresh_idle();
        int prea_n = 0, ref_n = 0, prea_cyc = -1, ref_cyc = -1, rdy_cyc = -1;
        logic [11:0] prea_bus = '0;
        do_reset();
        ref_en = 1'b1;
        run_to(99);
        checks++;
        if (ref_pending !== 4'd0 || cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL idle_pre_expire: got pend=%0d ready=%b expected 0/1",
                     ref_pending, cmd_ready);
        end
        tick();
        checks++;
        if (ref_pending !== 4'd1 || cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_expire: got pend=%0d ready=%b expected 1/0", ref_pending, cmd_ready);
        end
        while (cyc < 140) begin
            tick();
            if (ddr_pre[0] && ddr_pall[0]) begin
                prea_n++;
                prea_cyc = cyc;
                prea_bus = {ddr_pre, ddr_pall, ddr_nop};
            end
            if (ddr_ref[0]) begin
                ref_n++;
                ref_cyc = cyc;
            end
            if (cmd_ready && rdy_cyc < 0) rdy_cyc = cyc;
        end
        checks++;
        if (prea_n != 1 || prea_cyc != 105 || prea_bus !== 12'h11e) begin
            failures++;
            $display("FAIL idle_prea: got n=%0d at=%0d bus=%h expected 1 at 105 bus=11e",
                     prea_n, prea_cyc, prea_bus);
        end
        checks++;
        if (ref_n != 1 || ref_cyc != 109) begin
            failures++;
            $display("FAIL idle_ref: got n=%0d at=%0d expected 1 at 109", ref_n, ref_cyc);
        end
        checks++;
        if (rdy_cyc != 129) begin
            failures++;
            $display("FAIL idle_ready_return: got %0d expected 129", rdy_cyc);
        end
        checks++;
        if (ref_issued !== 32'd1 || ref_pending !== 4'd0) begin
            failures++;
            $display("FAIL idle_counts: got iss=%0d pend=%0d expected 1/0", ref_issued, ref_pending);
        end
    endtask

    task automatic test_act();
        do_reset();
        ref_en = 1'b1;
        cmd_valid = 1'b1; cmd_type = 3'd1; cmd_bg = 2'd1; cmd_bank = 2'd2;
        cmd_row = 17'h1abc; cmd_col = 10'h3ff; cmd_ap = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL act_ready: got %b expected 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (ddr_act !== 4'b0001 || ddr_nop !== 4'b1110 || ddr_ap !== 4'b0000) begin
            failures++;
            $display("FAIL act_flags: got act=%b nop=%b ap=%b expected 0001/1110/0000",
                     ddr_act, ddr_nop, ddr_ap);
        end
        checks++;
        if (ddr_row !== 68'h1abc || ddr_bg !== 8'h01 || ddr_bank !== 8'h02 || ddr_col !== 40'h0)
        begin
            failures++;
            $display("FAIL act_addr: got row=%h bg=%h bank=%h col=%h expected 1abc/01/02/0",
                     ddr_row, ddr_bg, ddr_bank, ddr_col);
        end
        tick();
        checks++;
        if (ddr_nop !== 4'b1111 || ddr_act !== 4'b0000 || ddr_row !== 68'h0) begin
            failures++;
            $display("FAIL act_after: got nop=%b act=%b row=%h expected 1111/0000/0",
                     ddr_nop, ddr_act, ddr_row);
        end
    endtask

    // Back-to-back host commands; expected slot-0 flags {wr,rd,pre,act,ref,zq,nop,ap,pall}
    task automatic test_cmd_types();
        logic [2:0] vt_type [8];
        logic       vt_ap   [8];
        logic [8:0] vt_flag [8];
        logic [9:0] vt_col  [8];
        logic [1:0] vt_bg   [8];
        logic [8:0] got;
        logic [26:0] hi;
        vt_type = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd3};
        vt_ap   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vt_flag = '{9'b010000010, 9'b100000000, 9'b001000000, 9'b001000001,
                    9'b000010000, 9'b000001000, 9'b000000100, 9'b100000010};
        vt_col  = '{10'h155, 10'h155, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h155};
        vt_bg   = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd2};
        do_reset();
        ref_en = 1'b1;
        cmd_valid = 1'b1; cmd_bg = 2'd2; cmd_bank = 2'd3; cmd_col = 10'h155; cmd_row = 17'h5;
        for (int i = 0; i < 8; i++) begin
            cmd_type = vt_type[i];
            cmd_ap = vt_ap[i];
            tick();
            got = {ddr_write[0], ddr_read[0], ddr_pre[0], ddr_act[0], ddr_ref[0], ddr_zq[0],
                   ddr_nop[0], ddr_ap[0], ddr_pall[0]};
            hi = {ddr_write[3:1], ddr_read[3:1], ddr_pre[3:1], ddr_act[3:1], ddr_ref[3:1],
                  ddr_zq[3:1], ddr_nop[3:1], ddr_ap[3:1], ddr_pall[3:1]};
            checks++;
            if (got !== vt_flag[i] || hi !== 27'h1c0) begin
                failures++;
                $display("FAIL type_flags[%0d]: got %b hi=%h expected %b hi=1c0",
                         i, got, hi, vt_flag[i]);
            end
            checks++;
            if (ddr_col !== {30'h0, vt_col[i]} || ddr_bg !== {6'h0, vt_bg[i]}) begin
                failures++;
                $display("FAIL type_addr[%0d]: got col=%h bg=%h expected col=%h bg=%h",
                         i, ddr_col, ddr_bg, vt_col[i], vt_bg[i]);
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (ref_pending !== 4'd0 || ref_issued !== 32'd0) begin
            failures++;
            $display("FAIL host_ref_no_effect: got pend=%0d iss=%0d expected 0/0",
                     ref_pending, ref_issued);
        end
    endtask

    task automatic test_continuous();
        int acc = 0, stall = 0, first_stall = -1, prea_n = 0, ref_n = 0;
        logic [3:0] p399 = '0, p400 = '0, p429 = '0;
        do_reset();
        ref_en = 1'b1;
        cmd_valid = 1'b1; cmd_type = 3'd3; cmd_col = 10'h7;
        while (cyc < 500) begin
            if (cmd_ready) acc++;
            else begin
                stall++;
                if (first_stall < 0) first_stall = cyc;
            end
            if (ddr_pre[0] && ddr_pall[0]) prea_n++;
            if (ddr_ref[0]) ref_n++;
            if (cyc == 399) p399 = ref_pending;
            if (cyc == 400) p400 = ref_pending;
            if (cyc == 429) p429 = ref_pending;
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (p399 !== 4'd3 || p400 !== 4'd4) begin
            failures++;
            $display("FAIL cont_climb: got %0d,%0d expected 3,4", p399, p400);
        end
        checks++;
        if (first_stall != 400 || stall != 29 || acc != 471) begin
            failures++;
            $display("FAIL cont_stall: got first=%0d stalls=%0d acc=%0d expected 400/29/471",
                     first_stall, stall, acc);
        end
        checks++;
        if (prea_n != 1 || ref_n != 1 || p429 !== 4'd3) begin
            failures++;
            $display("FAIL cont_seq: got prea=%0d ref=%0d pend=%0d expected 1/1/3",
                     prea_n, ref_n, p429);
        end
        checks++;
        if (ref_overflow !== 1'b0) begin
            failures++;
            $display("FAIL cont_overflow: got %b expected 0", ref_overflow);
        end
    endtask

    task automatic test_overflow();
        logic [3:0] p40 = '0, p49 = '0, p59 = '0, p60 = '0;
        logic       o59 = 1'b1, o60 = 1'b0, r59 = 1'b1;
        do_reset();
        ref_en = 1'b1;
        cmd_valid = 1'b1; cmd_type = 3'd2;
        while (cyc < 100) begin
            if (cyc == 40) p40 = b_pending;
            if (cyc == 49) p49 = b_pending;
            if (cyc == 59) begin p59 = b_pending; o59 = b_overflow; r59 = b_cmd_ready; end
            if (cyc == 60) begin p60 = b_pending; o60 = b_overflow; end
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (p40 !== 4'd4 || p49 !== 4'd3) begin
            failures++;
            $display("FAIL ovf_climb: got %0d,%0d expected 4,3", p40, p49);
        end
        checks++;
        if (p59 !== 4'd4 || o59 !== 1'b0 || r59 !== 1'b0) begin
            failures++;
            $display("FAIL ovf_before: got pend=%0d ovf=%b ready=%b expected 4/0/0",
                     p59, o59, r59);
        end
        checks++;
        if (p60 !== 4'd4 || o60 !== 1'b1) begin
            failures++;
            $display("FAIL ovf_set: got pend=%0d ovf=%b expected 4/1", p60, o60);
        end
        checks++;
        if (b_overflow !== 1'b1 || b_pending !== 4'd4) begin
            failures++;
            $display("FAIL ovf_sticky: got ovf=%b pend=%0d expected 1/4", b_overflow, b_pending);
        end
    endtask

    task automatic test_expire_on_ref();
        do_reset();
        ref_en = 1'b1;
        cmd_valid = 1'b1; cmd_type = 3'd0;
        run_to(291);
        cmd_valid = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b0 || ref_pending !== 4'd2) begin
            failures++;
            $display("FAIL same_start: got ready=%b pend=%0d expected 0/2", cmd_ready, ref_pending);
        end
        run_to(299);
        checks++;
        if (ref_pending !== 4'd2) begin
            failures++;
            $display("FAIL same_before: got %0d expected 2", ref_pending);
        end
        tick();
        checks++;
        if (ref_pending !== 4'd2 || ddr_ref !== 4'b0001 || ref_issued !== 32'd1) begin
            failures++;
            $display("FAIL same_cycle: got pend=%0d ref=%b iss=%0d expected 2/0001/1",
                     ref_pending, ddr_ref, ref_issued);
        end
    endtask

    task automatic test_ref_en_drop();
        int ref_cyc = -1, prea_after = 0;
        logic rdy230 = 1'b0;
        do_reset();
        ref_en = 1'b1;
        cmd_valid = 1'b1; cmd_type = 3'd0;
        run_to(201);
        cmd_valid = 1'b0;
        run_to(207);
        ref_en = 1'b0;
        while (cyc < 520) begin
            tick();
            if (ddr_ref[0] && ref_cyc < 0) ref_cyc = cyc;
            if (cyc > 210 && ddr_pre[0]) prea_after++;
            if (cyc == 230) rdy230 = cmd_ready;
        end
        checks++;
        if (ref_cyc != 210) begin
            failures++;
            $display("FAIL en_drop_ref: got %0d expected 210", ref_cyc);
        end
        checks++;
        if (prea_after != 0 || rdy230 !== 1'b1) begin
            failures++;
            $display("FAIL en_drop_quiet: got prea=%0d ready=%b expected 0/1", prea_after, rdy230);
        end
        checks++;
        if (ref_pending !== 4'd1 || ref_issued !== 32'd1) begin
            failures++;
            $display("FAIL en_drop_hold: got pend=%0d iss=%0d expected 1/1",
                     ref_pending, ref_issued);
        end
    endtask

    task automatic test_rst_mid();
        int prea_n = 0;
        do_reset();
        ref_en = 1'b1;
        run_to(115);
        checks++;
        if (cmd_ready !== 1'b0 || ref_issued !== 32'd1) begin
            failures++;
            $display("FAIL rst_mid_pre: got ready=%b iss=%0d expected 0/1", cmd_ready, ref_issued);
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq, ddr_ap, ddr_pall} !== 32'h0
            || ddr_nop !== 4'hf || {ddr_bg, ddr_bank, ddr_col, ddr_row} !== 124'h0) begin
            failures++;
            $display("FAIL rst_mid_bus: got nop=%b flags=%h expected 1111/0", ddr_nop,
                     {ddr_write, ddr_read, ddr_pre, ddr_act, ddr_ref, ddr_zq, ddr_ap, ddr_pall});
        end
        checks++;
        if ({cmd_ready, ref_pending, ref_issued, ref_overflow} !== 38'h0) begin
            failures++;
            $display("FAIL rst_mid_status: got ready=%b pend=%0d iss=%0d ovf=%b expected 0",
                     cmd_ready, ref_pending, ref_issued, ref_overflow);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_idle: got ready=%b expected 1", cmd_ready);
        end
        repeat (30) begin
            tick();
            if (ddr_pre[0] || ddr_ref[0]) prea_n++;
        end
        checks++;
        if (prea_n != 0) begin
            failures++;
            $display("FAIL rst_mid_quiet: got %0d refresh cmds expected 0", prea_n);
        end
    endtask

    initial begin
        test_reset();
        test_refresh_idle();
        test_act();
        test_cmd_types();
        test_continuous();
        test_overflow();
        test_expire_on_ref();
        test_ref_en_drop();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
